bench_pattern_sequencer: RTL
============================

# bench_pattern_sequencer

Exhaustive stimulus sequencer and response compactor for small combinational/sequential benchmark circuits under trojan-detection test. It walks every input pattern of an N_IN-bit DUT in ascending binary order, waits a programmable settle time, samples the DUT's single output and streams each (pattern, response) pair over a valid/ready port. It also folds every response into a MISR signature for golden-vs-suspect comparison. It sits between the test controller and the benchmark instance and replaces per-bench hand-written pattern loops.

## Interface
- N_IN, 3, DUT input width; pattern space 2^N_IN
- SETTLE_CYC, 1, cycles between pattern drive and capture (0 legal)
- SIG_W, 16, signature width
- POLY, 16'h1021, MISR feedback polynomial (SIG_W bits)
- CK  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; honoured only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of sweep
- pat_o  out  N_IN  pattern driven to DUT inputs (pat_o[0] is the MSB of the pattern, matching DUT port order N[0]..N[N_IN-1])
- dut_out_i  in  1  DUT output
- res_valid  out  1  result beat valid
- res_ready  in  1  consumer ready
- res_pat  out  N_IN  pattern of current result beat
- res_bit  out  1  captured DUT output for res_pat
- signature  out  SIG_W  running MISR value

## Operation
- States: IDLE, APPLY, SETTLE, CAPTURE, EMIT, DONE.
- IDLE: if start, then pat_o<=0, signature<=0, go to APPLY. Otherwise hold.
- APPLY: pat_o is stable; load settle counter with SETTLE_CYC. Go to SETTLE if SETTLE_CYC>0, else CAPTURE.
- SETTLE: decrement counter; at 1, go to CAPTURE.
- CAPTURE: res_pat<=pat_o, res_bit<=dut_out_i, signature<=({sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0)) ^ dut_out_i. Go to EMIT.
- EMIT: res_valid=1. Hold res_pat and res_bit stable until res_ready. On handshake: if pat_o is all-ones, go to DONE; else pat_o<=pat_o+1 and go to APPLY.
- DONE: done=1 for one cycle, then IDLE. pat_o and signature hold their final values until the next start.
- start outside IDLE is ignored. Pattern counter never wraps within a sweep.

## Timing
- Reset values: state=IDLE, busy=0, done=0, res_valid=0, pat_o=0, res_pat=0, res_bit=0, signature=0.
- Start sampled at edge k gives busy=1 from k+1. Per pattern: 3+SETTLE_CYC cycles with res_ready held high; each extra stall cycle adds one.
- With res_ready=1, done is asserted 2^N_IN*(3+SETTLE_CYC) cycles after busy rises (N_IN=3, S=1: 32 cycles). busy drops in the same cycle done pulses.
- res_valid is a Moore output of EMIT. It must not depend combinationally on res_ready.
- Reset mid-sweep: all outputs take reset values at the next edge. No done pulse and no further res_valid are issued.
- start coincident with reset: reset wins.

## Structure
- Package bench_seq_pkg: state enum seq_state_t, DEFAULT_POLY constant, signature update function misr_step.
- One sub-module, misr_accum (SIG_W, POLY): clear, enable, bit in, signature out. It is instantiated once and reusable by other compaction benches.
- Settle counter width is $clog2(SETTLE_CYC+1), with a minimum of 1.

## Test plan
- DUT output tied 0, res_ready=1, N_IN=3, S=1 -> 8 beats with res_pat 0..7 in order, all res_bit=0; signature=16'h0000; done at busy+32.
- DUT output tied 1 -> 8 beats with res_bit=1; final signature=16'h00FF.
- DUT output =1 only for pattern 000 -> final signature=16'h0080; res_bit sequence 1,0,0,0,0,0,0,0.
- res_ready toggled 0/1 every cycle -> res_pat and res_bit stable while stalled; no pattern skipped or duplicated; done delayed exactly by the stall count.
- Reset asserted during the EMIT of pattern 4 -> next cycle all outputs are 0 and state is IDLE; a new start restarts at pattern 0 with signature 0.
- start pulsed while busy, and SETTLE_CYC=0 build -> extra start ignored; sweep finishes in 24 cycles.

Source files
------------

// File: rtl/bench_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bench_seq_pkg
//  Description : Shared types, constants and the MISR update step for the
//                benchmark pattern sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package bench_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_EMIT    = 3'd4,
    S_DONE    = 3'd5
  } seq_state_t;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;

  // Width-generic MISR step on a 64-bit carrier; callers truncate to their width.
  function automatic logic [63:0] misr_step(
    input logic [63:0] sig,
    input logic [63:0] poly,
    input logic        bit_in,
    input int unsigned width
  );
    logic [63:0] mask;
    logic [63:0] nxt;
    logic        msb;
    mask   = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    msb    = |(sig & (64'd1 << (width - 1)));
    nxt    = (sig << 1) ^ (msb ? poly : 64'd0);
    nxt[0] = nxt[0] ^ bit_in;
    return nxt & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/misr_accum.sv
`default_nettype none
// ============================================================================
//  Module      : misr_accum
//  Description : Single-input MISR response compactor with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module misr_accum
  import bench_seq_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_bit,
  output logic [SIG_W-1:0] o_signature
);

  logic [SIG_W-1:0] r_sig;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_sig <= '0;
    end else if (i_enable) begin
      r_sig <= SIG_W'(misr_step(64'(r_sig), 64'(POLY), i_bit, SIG_W));
    end
  end

  assign o_signature = r_sig;

endmodule
`default_nettype wire

// File: rtl/bench_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bench_pattern_sequencer
//  Description : Exhaustive ascending pattern sweep with settle delay, streamed
//                (pattern, response) beats and MISR signature of responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module bench_pattern_sequencer
  import bench_seq_pkg::*;
#(
  parameter int               N_IN       = 3,
  parameter int               SETTLE_CYC = 1,
  parameter int               SIG_W      = 16,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(DEFAULT_POLY)
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  pat_o,
  input  logic             dut_out_i,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N_IN-1:0]  res_pat,
  output logic             res_bit,
  output logic [SIG_W-1:0] signature
);

  localparam int                 c_CNT_W  = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_SETTLE = c_CNT_W'(SETTLE_CYC);

  seq_state_t         r_state;
  seq_state_t         w_next_state;
  logic [N_IN-1:0]    r_pat;
  logic [N_IN-1:0]    r_res_pat;
  logic               r_res_bit;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_last;
  logic               w_accept;
  logic               w_handshake;
  logic               w_sig_clear;
  logic               w_sig_en;

  assign w_last      = &r_pat;
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_handshake = (r_state == S_EMIT) && res_ready;

  always_ff @(posedge CK) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_sig_clear  = 1'b0;
    w_sig_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_APPLY;
          w_sig_clear  = 1'b1;
        end
      end
      S_APPLY:   w_next_state = (SETTLE_CYC > 0) ? S_SETTLE : S_CAPTURE;
      S_SETTLE: begin
        if (r_cnt == c_CNT_W'(1)) begin
          w_next_state = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_sig_en     = 1'b1;
        w_next_state = S_EMIT;
      end
      S_EMIT: begin
        if (res_ready) begin
          w_next_state = w_last ? S_DONE : S_APPLY;
        end
      end
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      r_pat     <= '0;
      r_res_pat <= '0;
      r_res_bit <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_pat <= '0;
      end else if (w_handshake && !w_last) begin
        r_pat <= r_pat + N_IN'(1);
      end
      if (r_state == S_APPLY) begin
        r_cnt <= c_SETTLE;
      end else if (r_state == S_SETTLE) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end
      if (r_state == S_CAPTURE) begin
        r_res_pat <= r_pat;
        r_res_bit <= dut_out_i;
      end
    end
  end

  misr_accum #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk         (CK),
    .rst         (reset),
    .i_clear     (w_sig_clear),
    .i_enable    (w_sig_en),
    .i_bit       (dut_out_i),
    .o_signature (signature)
  );

  // DUT port N[0] takes the pattern MSB, so the drive bus is bit-reversed.
  for (genvar i = 0; i < N_IN; i++) begin : g_pat_rev
    assign pat_o[i] = r_pat[N_IN-1-i];
  end

  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign res_valid = (r_state == S_EMIT);
  assign res_pat   = r_res_pat;
  assign res_bit   = r_res_bit;

endmodule
`default_nettype wire
